// File: rtl/fib_stack.sv
// LIFO operand stack for the Fibonacci datapath controller: push/pop/top strobes, registered read data,
// occupancy and sticky error status. Define FIB_STACK_HIGH_WATER_EN to add the max_count high-water output.
module fib_stack #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic              top,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              is_empty,
    output logic              is_full,
    output logic [PTR_W:0]    count,
`ifdef FIB_STACK_HIGH_WATER_EN
    output logic [PTR_W:0]    max_count,
`endif
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0]   DEPTH   = (PTR_W+1)'(1) << PTR_W;
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [2**PTR_W];
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  tos;
    logic              empty;
    logic              full;

    assign sp    = count_q[PTR_W-1:0];
    assign tos   = sp - PTR_ONE;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH);

    // Commands are single-cycle strobes with no handshake: whatever is asserted at a rising edge
    // completes at that edge. clr beats everything; pop beats top; push+pop on a non-empty stack
    // replaces the top entry; push+top reads the old top and then pushes.
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we      = 1'b0;
        waddr   = sp;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (push && pop) begin
            we = 1'b1;
            if (!empty) begin
                dout_d = mem_q[tos];
                waddr  = tos;
            end else begin
                count_d = count_q + CNT_ONE;
                udf_d   = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                dout_d  = mem_q[tos];
                count_d = count_q - CNT_ONE;
            end else begin
                udf_d = 1'b1;
            end
        end else begin
            if (top) begin
                if (!empty) dout_d = mem_q[tos];
                else        udf_d  = 1'b1;
            end
            if (push) begin
                if (!full) begin
                    we      = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage carries no reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= din;
    end

`ifdef FIB_STACK_HIGH_WATER_EN
    logic [PTR_W:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (clr)                  max_d = '0;
        else if (count_d > max_q) max_d = count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) max_q <= '0;
        else     max_q <= max_d;
    end

    assign max_count = max_q;
`endif

    assign dout      = dout_q;
    assign count     = count_q;
    assign is_empty  = empty;
    assign is_full   = full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_fib_stack.sv
// Directed scoreboard bench for fib_stack; expectations are queued per driven cycle and checked by a monitor.
module tb_fib_stack;

    localparam int DATA_W = 16;
    localparam int PTR_W  = 5;
    localparam int CW     = PTR_W + 1;
`ifdef FIB_STACK_HIGH_WATER_EN
    localparam int W = DATA_W + CW + 4 + CW;
`else
    localparam int W = DATA_W + CW + 4;
`endif

    logic              clk;
    logic              rst;
    logic              clr;
    logic              push;
    logic              pop;
    logic              top;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              is_empty;
    logic              is_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
`ifdef FIB_STACK_HIGH_WATER_EN
    logic [CW-1:0]     max_count;
`endif

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;
    logic [CW-1:0] m_max;

    fib_stack #(.DATA_W(DATA_W), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .top       (top),
        .din       (din),
        .dout      (dout),
        .is_empty  (is_empty),
        .is_full   (is_full),
        .count     (count),
`ifdef FIB_STACK_HIGH_WATER_EN
        .max_count (max_count),
`endif
        .overflow  (overflow),
        .underflow (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic [DATA_W-1:0] d, input logic [CW-1:0] c,
                                          input logic e, input logic f, input logic o, input logic u,
                                          input logic [CW-1:0] mx);
`ifdef FIB_STACK_HIGH_WATER_EN
        return {d, c, e, f, o, u, mx};
`else
        logic [CW-1:0] unused;
        unused = mx;
        return {d, c, e, f, o, u};
`endif
    endfunction

    function automatic logic [W-1:0] actual();
`ifdef FIB_STACK_HIGH_WATER_EN
        return pack(dout, count, is_empty, is_full, overflow, underflow, max_count);
`else
        return pack(dout, count, is_empty, is_full, overflow, underflow, '0);
`endif
    endfunction

    // driver: one command per cycle, expected post-edge state queued alongside
    task automatic step(input string nm, input logic c, input logic p, input logic po, input logic t,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e_dout,
                        input logic [CW-1:0] e_cnt, input logic e_ovf, input logic e_udf);
        @(negedge clk);
        clr  = c;
        push = p;
        pop  = po;
        top  = t;
        din  = d;
        if (c) m_max = '0;
        else if (e_cnt > m_max) m_max = e_cnt;
        exp_q.push_back(pack(e_dout, e_cnt, e_cnt == 0, e_cnt == CW'(32), e_ovf, e_udf, m_max));
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    always @(posedge clk or posedge rst) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        string        nm;
        #1;
        if (rst) begin
            got = actual();
            exp = pack('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks = checks + 1;
            if (got !== exp) begin
                errors = errors + 1;
                $display("FAIL reset_state: got %h required %h", got, exp);
            end
        end else if (exp_q.size() > 0) begin
            got = actual();
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks = checks + 1;
            if (got !== exp) begin
                errors = errors + 1;
                $display("FAIL %s: got %h required %h (dout,count,empty,full,ovf,udf)", nm, got, exp);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_max  = '0;
        rst  = 1'b0;
        clr  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        top  = 1'b0;
        din  = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 3; i++) step("idle_after_reset", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);

        // push 5, 8, 13 then drain
        step("push5",  0, 1, 0, 0, 16'd5,  16'h0,  1, 0, 0);
        step("push8",  0, 1, 0, 0, 16'd8,  16'h0,  2, 0, 0);
        step("push13", 0, 1, 0, 0, 16'd13, 16'h0,  3, 0, 0);
        step("pop13",  0, 0, 1, 0, 16'h0,  16'd13, 2, 0, 0);
        step("pop8",   0, 0, 1, 0, 16'h0,  16'd8,  1, 0, 0);
        step("pop5",   0, 0, 1, 0, 16'h0,  16'd5,  0, 0, 0);
        step("idle_empty", 0, 0, 0, 0, 16'h0, 16'd5, 0, 0, 0);

        // peek keeps count
        step("push7fff", 0, 1, 0, 0, 16'h7FFF, 16'd5,    1, 0, 0);
        step("top1",     0, 0, 0, 1, 16'h0,    16'h7FFF, 1, 0, 0);
        step("top2",     0, 0, 0, 1, 16'h0,    16'h7FFF, 1, 0, 0);
        step("pop7fff",  0, 0, 1, 1, 16'h0,    16'h7FFF, 0, 0, 0);

        // fill to DEPTH, overflow and sticky flag
        for (int i = 0; i < 32; i++)
            step("fill", 0, 1, 0, 0, DATA_W'(i), 16'h7FFF, CW'(i + 1), 0, 0);
        step("push_full",      0, 1, 0, 0, 16'd99, 16'h7FFF, 32, 1, 0);
        step("pop_after_full", 0, 0, 1, 0, 16'h0,  16'd31,   31, 1, 0);
        step("top_30",         0, 0, 0, 1, 16'h0,  16'd30,   31, 1, 0);
        step("push_top_fill",  0, 1, 0, 1, 16'd77, 16'd30,   32, 1, 0);
        step("push_top_full",  0, 1, 0, 1, 16'd88, 16'd77,   32, 1, 0);
        step("replace_full",   0, 1, 1, 0, 16'd55, 16'd77,   32, 1, 0);
        step("pop_replaced",   0, 0, 1, 0, 16'h0,  16'd55,   31, 1, 0);
        step("clr",            0, 0, 0, 0, 16'h0,  16'd55,   31, 1, 0);
        step("clr_flush",      1, 0, 0, 0, 16'h0,  16'd55,   0,  0, 0);
        step("clr_beats_push", 1, 1, 0, 0, 16'd9,  16'd55,   0,  0, 0);

        // underflow and empty-stack combinations
        step("pop_empty",      0, 0, 1, 0, 16'h0, 16'd55, 0, 0, 1);
        step("top_empty",      0, 0, 0, 1, 16'h0, 16'd55, 0, 0, 1);
        step("push_pop_empty", 0, 1, 1, 0, 16'd1, 16'd55, 1, 0, 1);
        step("push2",          0, 1, 0, 0, 16'd2, 16'd55, 2, 0, 1);
        step("replace_2_by_4", 0, 1, 1, 1, 16'd4, 16'd2,  2, 0, 1);
        step("pop4",           0, 0, 1, 0, 16'h0, 16'd4,  1, 0, 1);
        step("pop1",           0, 0, 1, 0, 16'h0, 16'd1,  0, 0, 1);
        step("clr_udf",        1, 0, 0, 0, 16'h0, 16'd1,  0, 0, 0);
        step("push_top_empty", 0, 1, 0, 1, 16'd3, 16'd1,  1, 0, 1);
        step("pop3",           0, 0, 1, 0, 16'h0, 16'd3,  0, 0, 1);
        step("clr_again",      1, 0, 0, 0, 16'h0, 16'd3,  0, 0, 0);

        // push burst interrupted by asynchronous reset
        for (int i = 0; i < 6; i++)
            step("burst", 0, 1, 0, 0, DATA_W'(10 + i), 16'd3, CW'(i + 1), 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        m_max = '0;
        @(negedge clk);
        push = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step("idle_after_rst", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        step("push_after_rst", 0, 1, 0, 0, 16'd21, 16'h0, 1, 0, 0);
        step("top_after_rst",  0, 0, 0, 1, 16'h0, 16'd21, 1, 0, 0);
        step("idle_end",       0, 0, 0, 0, 16'h0, 16'd21, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_stack.md
Name: fib_stack

Overview:
- LIFO operand stack serving the Fibonacci datapath controller.
- Responds to the controller's push/pop/top command strobes.
- Writes operands selected by the datapath stack-input mux; returns popped or peeked values on a registered output.
- Reports occupancy status so the controller can branch on empty, e.g. terminate when the stack drains.

Parameters:
DATA_W, 16, width of each stack entry (two's-complement operand/result)
PTR_W, 5, pointer width; DEPTH = 2**PTR_W entries (default 32)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
clr  input  1  synchronous flush: empties stack, clears error flags
push  input  1  write din onto stack this cycle
pop  input  1  read top entry to dout and remove it
top  input  1  read top entry to dout without removing it
din  input  DATA_W  data to push
dout  output  DATA_W  registered read data
is_empty  output  1  count == 0 (decoded from registered count)
is_full  output  1  count == DEPTH
count  output  PTR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop/top attempted while empty

Behaviour:
- Reset (rst=1, async): count=0, dout=0, overflow=0, underflow=0, memory contents don't-care. Outputs hold until the first rising edge after rst deasserts.
- Storage: DEPTH x DATA_W register array indexed by sp=count[PTR_W-1:0]; top-of-stack = mem[count-1].
- Single-cycle response: command sampled at edge N; dout/count/flags valid after edge N.
  - Controller samples is_empty in the state following a pop, which sees post-pop occupancy.
- push only: if !is_full, mem[count]<=din and count<=count+1. If full: no write, count unchanged, overflow<=1.
- pop only: if !is_empty, dout<=mem[count-1] and count<=count-1. If empty: dout unchanged, count unchanged, underflow<=1.
- top only: if !is_empty, dout<=mem[count-1], count unchanged. If empty: dout unchanged, underflow<=1.
- pop and top together: treated as pop.
- push with pop (top ignored), non-empty: replace operation.
  - dout<=mem[count-1], mem[count-1]<=din, count unchanged.
  - Never sets overflow, even when full.
- push with pop, empty: push executes (mem[0]<=din, count<=1), dout unchanged, underflow<=1.
- push with top only (no pop), non-empty: dout<=mem[count-1] (old top), then push executes; if full, overflow<=1 and no write.
- push with top only, empty: push executes, underflow<=1.
- Idle (no strobes): all state holds; dout retains last read value.
- clr: highest priority synchronous action; count<=0, overflow<=0, underflow<=0, dout unchanged, any same-cycle command ignored.
- rst mid-operation: immediate return to reset values; in-flight command discarded.
- Arithmetic: count is PTR_W+1 bits so DEPTH is representable. Index arithmetic is modulo DEPTH; no wrap ever occurs because full/empty guards block it.
- No pipeline, no back-pressure; every command completes in one cycle.

Optional Feature:
- Macro: FIB_STACK_HIGH_WATER_EN.
- Defined: adds output max_count [PTR_W+1].
  - Reset/clr to 0.
  - Each cycle max_count <= max(max_count, next count).
  - Used to size DEPTH from simulation of worst-case Fibonacci recursion.
- Undefined: port and logic absent; interface is exactly the port list above.

Test Plan:
- Reset then idle 3 cycles -> count=0, is_empty=1, is_full=0, dout=0, overflow=underflow=0.
- Push 5, 8, 13 then pop x3 -> dout 13, 8, 5 on successive cycles; count 2, 1, 0; is_empty=1 on the cycle after the third pop.
- Push 0x7FFF then top twice -> dout=0x7FFF both cycles, count stays 1; then pop -> count=0, no flags.
- Fill 32 entries (values 0..31), push 99 -> is_full=1, overflow=1, count=32; pop -> dout=31; overflow stays 1 until clr.
- Empty stack, pop -> underflow=1, dout unchanged; push 4 with pop same cycle on stack [1,2] -> dout=2, stack [1,4], count=2.
- Assert rst asynchronously mid-push burst (count=6) -> count=0 immediately without clock; with FIB_STACK_HIGH_WATER_EN, max_count=6 before rst, 0 after.
